// File: rtl/fifo_dpram_pkg.sv
// Shared transaction-layer constants and flag helper for the FIFO
// and its bench.
package fifo_dpram_pkg;

    localparam int FIFO_DATA_WIDTH = 8;
    localparam int FIFO_ADDR_WIDTH = 6;
    localparam int FIFO_AF_TH      = 60;
    localparam int FIFO_AE_TH      = 4;

    typedef struct packed {
        logic full;
        logic empty;
        logic afull;
        logic aempty;
    } fifo_flags_t;

    function automatic fifo_flags_t calc_flags(
        input int cnt,
        input int depth,
        input int af_th,
        input int ae_th
    );
        fifo_flags_t f;
        f.full   = (cnt == depth);
        f.empty  = (cnt == 0);
        f.afull  = (cnt >= af_th);
        f.aempty = (cnt <= ae_th);
        return f;
    endfunction

endpackage

// File: rtl/fifo_dpram_dpram.sv
// Parametrised true dual-port RAM, single clock, registered q per port.
// Same-port read-during-write returns the old word.
module dpram_param #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_a,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] d_a,
    output logic [DATA_WIDTH-1:0] q_a,
    input  logic                  en_b,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] d_b,
    output logic [DATA_WIDTH-1:0] q_b
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en_a && we_a) r_mem[addr_a] <= d_a;
        if (en_b && we_b) r_mem[addr_b] <= d_b;
    end

    // Only the output registers clear; array contents survive reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_a <= '0;
            q_b <= '0;
        end else begin
            if (en_a) q_a <= r_mem[addr_a];
            if (en_b) q_b <= r_mem[addr_b];
        end
    end

endmodule

// File: rtl/fifo_dpram.sv
// Synchronous FIFO over dpram_param: port A writes, port B reads.
// Occupancy counter drives registered full/empty/threshold flags.
module fifo_dpram
    import fifo_dpram_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
    parameter int AF_TH      = FIFO_AF_TH,
    parameter int AE_TH      = FIFO_AE_TH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  err_overflow,
    output logic                  err_underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] L_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic                  w_pop_ok;
    logic                  w_push_ok;
    logic [ADDR_WIDTH:0]   w_cnt_nxt;
    fifo_flags_t           w_flags;
    logic [DATA_WIDTH-1:0] w_unused_q_a;

    assign w_pop_ok  = pop & ~empty;
    // A pop in the same cycle frees the slot, so full does not block.
    assign w_push_ok = push & (~full | w_pop_ok);

    always_comb begin
        w_cnt_nxt = count;
        if (w_push_ok && !w_pop_ok)
            w_cnt_nxt = count + L_ONE;
        else if (!w_push_ok && w_pop_ok)
            w_cnt_nxt = count - L_ONE;
    end

    assign w_flags = calc_flags(int'(w_cnt_nxt), DEPTH, AF_TH, AE_TH);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            count         <= '0;
            full          <= 1'b0;
            empty         <= 1'b1;
            almost_full   <= 1'b0;
            almost_empty  <= 1'b1;
            valid_out     <= 1'b0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            count         <= w_cnt_nxt;
            full          <= w_flags.full;
            empty         <= w_flags.empty;
            almost_full   <= w_flags.afull;
            almost_empty  <= w_flags.aempty;
            valid_out     <= w_pop_ok;
            err_overflow  <= push & ~w_push_ok;
            err_underflow <= pop & empty;
        end
    end

    dpram_param #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk    (clk),
        .rst    (reset),
        .en_a   (w_push_ok),
        .we_a   (w_push_ok & ~reset),
        .addr_a (r_wr_ptr),
        .d_a    (data_in),
        .q_a    (w_unused_q_a),
        .en_b   (w_pop_ok),
        .we_b   (1'b0),
        .addr_b (r_rd_ptr),
        .d_b    ('0),
        .q_b    (data_out)
    );

endmodule

// File: tb/tb_fifo_dpram.sv
// Bench for fifo_dpram: vector table for short sequences, queue model
// plus read scoreboard for long fills, overflow, wrap and reset.
module tb_fifo_dpram;
    import fifo_dpram_pkg::*;

    localparam int DW    = FIFO_DATA_WIDTH;
    localparam int AW    = FIFO_ADDR_WIDTH;
    localparam int DEPTH = 1 << AW;

    if (!(FIFO_AE_TH >= 0 && FIFO_AE_TH < FIFO_AF_TH && FIFO_AF_TH <= DEPTH)) begin : g_bad_params
        $error("illegal FIFO thresholds");
    end

    logic          clk;
    logic          reset;
    logic          push;
    logic [DW-1:0] data_in;
    logic          pop;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic [AW:0]   count;
    logic          full, empty, almost_full, almost_empty;
    logic          err_overflow, err_underflow;

    fifo_dpram dut (
        .clk           (clk),
        .reset         (reset),
        .push          (push),
        .data_in       (data_in),
        .pop           (pop),
        .data_out      (data_out),
        .valid_out     (valid_out),
        .count         (count),
        .full          (full),
        .empty         (empty),
        .almost_full   (almost_full),
        .almost_empty  (almost_empty),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] mq[$];
    logic [DW-1:0] sb[$];

    typedef struct {
        bit      rst;
        bit      push;
        bit      pop;
        bit [7:0] din;
        int      e_cnt;
        bit      e_empty;
        bit      e_valid;
        bit      e_udf;
        bit      e_ovf;
        bit [7:0] e_data;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [12:0] status_act();
        return {count, full, empty, almost_full, almost_empty,
                err_overflow, err_underflow, valid_out};
    endfunction

    task automatic step(input bit r, input bit pu, input logic [DW-1:0] d,
                        input bit po, input string nm);
        bit pok, puok, e_ovf, e_udf;
        int c;
        logic [12:0] exp;
        reset = r; push = pu; data_in = d; pop = po;
        pok = 0; puok = 0; e_ovf = 0; e_udf = 0;
        if (r) begin
            mq.delete();
            sb.delete();
        end else begin
            pok   = po && (mq.size() > 0);
            puok  = pu && (mq.size() < DEPTH || pok);
            e_udf = po && (mq.size() == 0);
            e_ovf = pu && !puok;
            if (pok)  sb.push_back(mq.pop_front());
            if (puok) mq.push_back(d);
        end
        @(posedge clk); #1;
        c = mq.size();
        exp = {c[AW:0], c == DEPTH, c == 0, c >= FIFO_AF_TH,
               c <= FIFO_AE_TH, e_ovf, e_udf, pok};
        chk({nm, ".status"}, 32'(status_act()), 32'(exp));
        if (r) chk({nm, ".rst_data"}, 32'(data_out), 32'h0);
        if (valid_out) begin
            if (sb.size() == 0) chk({nm, ".spurious_valid"}, 32'(valid_out), 32'h0);
            else chk({nm, ".data"}, 32'(data_out), 32'(sb.pop_front()));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; push = 1'b0; pop = 1'b0; data_in = '0;

        tbl[0]  = '{1, 0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00};
        tbl[1]  = '{0, 0, 1, 8'h00, 0, 1, 0, 1, 0, 8'h00};
        tbl[2]  = '{0, 1, 1, 8'h55, 1, 0, 0, 1, 0, 8'h00};
        tbl[3]  = '{0, 0, 1, 8'h00, 0, 1, 1, 0, 0, 8'h55};
        tbl[4]  = '{0, 1, 0, 8'h11, 1, 0, 0, 0, 0, 8'h55};
        tbl[5]  = '{0, 1, 0, 8'h22, 2, 0, 0, 0, 0, 8'h55};
        tbl[6]  = '{0, 1, 1, 8'h33, 2, 0, 1, 0, 0, 8'h11};
        tbl[7]  = '{0, 0, 0, 8'h00, 2, 0, 0, 0, 0, 8'h11};
        tbl[8]  = '{0, 0, 1, 8'h00, 1, 0, 1, 0, 0, 8'h22};
        tbl[9]  = '{0, 0, 1, 8'h00, 0, 1, 1, 0, 0, 8'h33};
        tbl[10] = '{0, 0, 1, 8'h00, 0, 1, 0, 1, 0, 8'h33};

        for (int i = 0; i < 11; i++) begin
            reset = tbl[i].rst; push = tbl[i].push;
            pop = tbl[i].pop; data_in = tbl[i].din;
            @(posedge clk); #1;
            chk($sformatf("vec%0d.count", i), 32'(count), 32'(tbl[i].e_cnt));
            chk($sformatf("vec%0d.flags", i),
                32'({empty, full, valid_out, err_underflow, err_overflow}),
                32'({tbl[i].e_empty, 1'b0, tbl[i].e_valid, tbl[i].e_udf, tbl[i].e_ovf}));
            chk($sformatf("vec%0d.data", i), 32'(data_out), 32'(tbl[i].e_data));
        end

        step(1, 0, 8'h00, 0, "reset");
        for (int i = 0; i < 10; i++) step(0, 0, 8'h00, 0, "idle");

        for (int i = 1; i <= DEPTH; i++) step(0, 1, 8'(i), 0, "fill");
        step(0, 1, 8'hAA, 0, "overflow");
        step(0, 0, 8'h00, 0, "post_ovf");
        for (int i = 0; i < DEPTH; i++) step(0, 0, 8'h00, 1, "drain");
        step(0, 0, 8'h00, 0, "drained");

        step(0, 1, 8'h55, 1, "push_pop_empty");
        step(0, 0, 8'h00, 1, "pop_55");
        step(0, 0, 8'h00, 0, "after_55");

        for (int i = 0; i < DEPTH; i++) step(0, 1, 8'(8'h80 + i), 0, "refill");
        for (int i = 0; i < 200; i++) step(0, 1, 8'(i), 1, "stream_full");
        for (int i = 0; i < DEPTH; i++) step(0, 0, 8'h00, 1, "drain2");
        step(0, 0, 8'h00, 0, "drained2");

        for (int i = 0; i < 20; i++) step(0, 1, 8'(8'h40 + i), 0, "pre_reset");
        step(1, 0, 8'h00, 1, "reset_during_pop");
        step(0, 0, 8'h00, 0, "after_reset");
        step(0, 0, 8'h00, 1, "pop_after_reset");
        for (int i = 0; i < 3; i++) step(0, 1, 8'(8'hC0 + i), 0, "push_c");
        for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 1, "pop_c");
        step(0, 0, 8'h00, 0, "final_idle");

        chk("scoreboard_empty", 32'(sb.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
